// File: rtl/time_pkg.sv
// ----------------------------------------------------------------------------
// time_pkg
// Shared constants for the time-of-day datapath (counter and digit converter).
// Contents:
//   state_t    : converter FSM encoding (IDLE / PREP / CONV)
//   NOON_CS    : centiseconds in twelve hours (12:00:00.00)
//   HOUR_CS    : centiseconds in one hour
//   NUM_DIGITS : number of BCD digits in HH:MM:SS.cc
//   weight_of  : centisecond weight of digit position k (k=0 is hour tens)
// ----------------------------------------------------------------------------
package time_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_CONV = 2'd2
   } state_t;

   localparam int unsigned NOON_CS    = 32'd4320000;
   localparam int unsigned HOUR_CS    = 32'd360000;
   localparam int unsigned NUM_DIGITS = 8;

   // Weight of each digit position, most significant first:
   // 10 h, 1 h, 10 min, 1 min, 10 s, 1 s, 10 cs, 1 cs.
   function automatic logic [31:0] weight_of(input logic [2:0] k);
      logic [31:0] w;
      case (k)
         3'd0:    w = 32'd3600000;
         3'd1:    w = 32'd360000;
         3'd2:    w = 32'd60000;
         3'd3:    w = 32'd6000;
         3'd4:    w = 32'd1000;
         3'd5:    w = 32'd100;
         3'd6:    w = 32'd10;
         default: w = 32'd1;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/time_digit_converter.sv
// ----------------------------------------------------------------------------
// time_digit_converter
// Converts a binary centisecond count into BCD digits HH:MM:SS.cc by repeated
// subtraction of per-digit weights (one subtract or one digit advance per
// clock). Optional 12-hour presentation with a PM flag.
// Ports:
//   i_Clk, i_Reset          : clock, asynchronous active-high reset
//   i_Start                 : request a conversion (accepted only when idle)
//   i_Count [BIT_WIDTH]     : centiseconds since midnight, sampled on accept
//   i_Mode_12h              : 1 = 12-hour output, sampled on accept
//   o_Busy                  : high from accept edge until the o_Valid edge
//   o_Valid                 : one-cycle pulse when new digits are presented
//   o_Hour_Tens..o_Centi_Units : BCD result digits, held between conversions
//   o_PM                    : afternoon flag (12-hour mode only)
//   o_Range_Err             : sampled count exceeded MAX_COUNT
// ----------------------------------------------------------------------------
module time_digit_converter
   import time_pkg::*;
#(
   parameter int BIT_WIDTH = 24,
   parameter int MAX_COUNT = 8639999
) (
   input  logic                 i_Clk,
   input  logic                 i_Reset,
   input  logic                 i_Start,
   input  logic [BIT_WIDTH-1:0] i_Count,
   input  logic                 i_Mode_12h,
   output logic                 o_Busy,
   output logic                 o_Valid,
   output logic [3:0]           o_Hour_Tens,
   output logic [3:0]           o_Hour_Units,
   output logic [3:0]           o_Min_Tens,
   output logic [3:0]           o_Min_Units,
   output logic [3:0]           o_Sec_Tens,
   output logic [3:0]           o_Sec_Units,
   output logic [3:0]           o_Centi_Tens,
   output logic [3:0]           o_Centi_Units,
   output logic                 o_PM,
   output logic                 o_Range_Err
);

   // One extra bit so the 12-hour "+noon" correction can never overflow.
   localparam int RW = BIT_WIDTH + 1;
   localparam logic [RW-1:0]        NOON    = RW'(NOON_CS);
   localparam logic [RW-1:0]        HOUR    = RW'(HOUR_CS);
   localparam logic [BIT_WIDTH-1:0] MAX_CNT = BIT_WIDTH'(MAX_COUNT);

   state_t          state_reg;
   logic [RW-1:0]   rem_reg;
   logic [2:0]      k_reg;
   logic            mode_reg;
   logic            pm_work_reg;
   logic            err_work_reg;
   logic [3:0]      work_reg  [NUM_DIGITS];
   logic [3:0]      digit_reg [NUM_DIGITS];
   logic            pm_reg;
   logic            err_reg;
   logic            valid_reg;
   logic            busy_reg;

   logic [RW-1:0]   weight;
   logic [RW-1:0]   prep_rem;
   logic            prep_pm;

   always_comb begin
      weight = RW'(weight_of(k_reg));

      // 12-hour fold: strip the afternoon half, then show hour 0 as 12.
      prep_rem = rem_reg;
      prep_pm  = 1'b0;
      if (rem_reg >= NOON) begin
         prep_rem = rem_reg - NOON;
         prep_pm  = 1'b1;
      end
      if (prep_rem < HOUR) begin
         prep_rem = prep_rem + NOON;
      end
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state_reg    <= ST_IDLE;
         rem_reg      <= '0;
         k_reg        <= '0;
         mode_reg     <= 1'b0;
         pm_work_reg  <= 1'b0;
         err_work_reg <= 1'b0;
         pm_reg       <= 1'b0;
         err_reg      <= 1'b0;
         valid_reg    <= 1'b0;
         busy_reg     <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            work_reg[i]  <= '0;
            digit_reg[i] <= '0;
         end
      end else begin
         valid_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (i_Start) begin
                  rem_reg      <= {1'b0, i_Count};
                  mode_reg     <= i_Mode_12h;
                  err_work_reg <= (i_Count > MAX_CNT);
                  pm_work_reg  <= 1'b0;
                  k_reg        <= '0;
                  busy_reg     <= 1'b1;
                  for (int i = 0; i < NUM_DIGITS; i++) begin
                     work_reg[i] <= '0;
                  end
                  state_reg    <= ST_PREP;
               end
            end

            ST_PREP: begin
               if (mode_reg) begin
                  rem_reg     <= prep_rem;
                  pm_work_reg <= prep_pm;
               end
               k_reg     <= '0;
               state_reg <= ST_CONV;
            end

            ST_CONV: begin
               if (rem_reg >= weight) begin
                  rem_reg         <= rem_reg - weight;
                  work_reg[k_reg] <= work_reg[k_reg] + 4'd1;
               end else if (k_reg == 3'd7) begin
                  // Publish the whole result in one edge so the outputs
                  // never show a partially converted time.
                  for (int i = 0; i < NUM_DIGITS; i++) begin
                     digit_reg[i] <= work_reg[i];
                  end
                  pm_reg    <= pm_work_reg;
                  err_reg   <= err_work_reg;
                  valid_reg <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= ST_IDLE;
               end else begin
                  k_reg <= k_reg + 3'd1;
               end
            end

            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign o_Busy        = busy_reg;
   assign o_Valid       = valid_reg;
   assign o_Hour_Tens   = digit_reg[0];
   assign o_Hour_Units  = digit_reg[1];
   assign o_Min_Tens    = digit_reg[2];
   assign o_Min_Units   = digit_reg[3];
   assign o_Sec_Tens    = digit_reg[4];
   assign o_Sec_Units   = digit_reg[5];
   assign o_Centi_Tens  = digit_reg[6];
   assign o_Centi_Units = digit_reg[7];
   assign o_PM          = pm_reg;
   assign o_Range_Err   = err_reg;

endmodule
